// File: rtl/tmds_serial_sequencer_pkg.sv
// Shared types and constants for the TMDS serializer sequencer.
package tmds_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} tmds_seq_state_t;
  localparam int TMDS_SYMBOL_BITS = 10;
  localparam int TMDS_CNT_W       = 4;
endpackage

// File: rtl/tmds_serial_sequencer_flex_counter.sv
// Loadable up-counter with programmable rollover; flag is high while count == rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = count_out;
    if (clear)
      cnt_d = '0;
    else if (count_enable)
      cnt_d = (count_out == rollover_val) ? NUM_CNT_BITS'(1) : count_out + 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= cnt_d;
      rollover_flag <= (cnt_d == rollover_val);
    end
  end
endmodule

// File: rtl/tmds_serial_sequencer.sv
// Load/shift sequencer for the three TMDS serializers plus divide-by-symbol pixel clock.
module tmds_serial_sequencer import tmds_pkg::*; #(
  parameter int SYMBOL_BITS = TMDS_SYMBOL_BITS,
  parameter int CLK_HIGH    = SYMBOL_BITS / 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  enable,
  input  logic                  data_ready,
  output logic                  pixel_ack,
  output logic                  load_enable,
  output logic                  shift_enable,
  output logic                  tmds_clk,
  output logic [TMDS_CNT_W-1:0] bit_count,
  output logic                  busy,
  output logic                  underflow
);
  localparam logic [TMDS_CNT_W-1:0] LAST_BIT = TMDS_CNT_W'(SYMBOL_BITS - 1);
  localparam logic [TMDS_CNT_W-1:0] HIGH_CNT = TMDS_CNT_W'(CLK_HIGH);

  tmds_seq_state_t state, next_state;
  logic armed, sym_end, cnt_clr, cnt_en;

  // Counter follows next_state so bit_count is already 0 in LOAD and 1 on the first shift.
  assign cnt_clr = (next_state != SHIFT);
  assign cnt_en  = (next_state == SHIFT);

  flex_counter #(.NUM_CNT_BITS(TMDS_CNT_W)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clr),
    .count_enable (cnt_en),
    .rollover_val (LAST_BIT),
    .count_out    (bit_count),
    .rollover_flag(sym_end)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      armed     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= next_state;
      armed     <= 1'b1;
      underflow <= (state == SHIFT) & sym_end & enable & ~data_ready;
    end
  end

  // armed blocks a load on the first edge after reset release.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (armed & enable & data_ready) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (sym_end) next_state = (enable & data_ready) ? LOAD : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_enable  = (state == LOAD);
    shift_enable = (state == SHIFT);
    busy         = (state != IDLE);
    pixel_ack    = load_enable;
    tmds_clk     = busy & (bit_count < HIGH_CNT);
  end
endmodule

// File: tb/tb_tmds_serial_sequencer.sv
// Two sequencers (10- and 8-bit symbols) on shared stimulus, checked against a symbol-timeline model.
module tb_tmds_serial_sequencer;
  typedef struct packed {
    logic       ack, ld, sh, tc, bsy, uf;
    logic [3:0] bc;
  } obs_t;

  logic clk = 1'b0, n_rst = 1'b0, enable = 1'b0, data_ready = 1'b0;
  logic ack0, ld0, sh0, tc0, bsy0, uf0, ack1, ld1, sh1, tc1, bsy1, uf1;
  logic [3:0] bc0, bc1;
  obs_t obs0, obs1;
  obs_t q0[$], q1[$];
  int checks = 0, errors = 0;
  int pos[2];
  bit armed[2];

  always #5 clk = ~clk;

  tmds_serial_sequencer #(.SYMBOL_BITS(10)) dut0 (
    .clk(clk), .n_rst(n_rst), .enable(enable), .data_ready(data_ready),
    .pixel_ack(ack0), .load_enable(ld0), .shift_enable(sh0), .tmds_clk(tc0),
    .bit_count(bc0), .busy(bsy0), .underflow(uf0));

  tmds_serial_sequencer #(.SYMBOL_BITS(8)) dut1 (
    .clk(clk), .n_rst(n_rst), .enable(enable), .data_ready(data_ready),
    .pixel_ack(ack1), .load_enable(ld1), .shift_enable(sh1), .tmds_clk(tc1),
    .bit_count(bc1), .busy(bsy1), .underflow(uf1));

  assign obs0 = '{ack0, ld0, sh0, tc0, bsy0, uf0, bc0};
  assign obs1 = '{ack1, ld1, sh1, tc1, bsy1, uf1, bc1};

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got ack=%b ld=%b sh=%b tclk=%b busy=%b uf=%b bc=%0d, expected ack=%b ld=%b sh=%b tclk=%b busy=%b uf=%b bc=%0d",
               name, $time, got.ack, got.ld, got.sh, got.tc, got.bsy, got.uf, got.bc,
               exp.ack, exp.ld, exp.sh, exp.tc, exp.bsy, exp.uf, exp.bc);
    end
  endtask

  // Model: pos is the index of the symbol bit on the wire, -1 when no symbol is in flight.
  function automatic obs_t model_step(input int k, input int n, input logic en, input logic dr);
    obs_t e;
    int p = pos[k];
    logic u = 1'b0;
    if (p == n - 1 || (p < 0 && armed[k])) begin
      if (en && dr) p = 0;
      else begin
        u = (p == n - 1) && en;
        p = -1;
      end
    end else if (p >= 0) p++;
    armed[k] = 1'b1;
    pos[k]   = p;
    e.ld  = (p == 0);
    e.ack = (p == 0);
    e.sh  = (p > 0);
    e.bsy = (p >= 0);
    e.tc  = (p >= 0) && (p < n / 2);
    e.uf  = u;
    e.bc  = (p < 0) ? 4'd0 : 4'(p);
    return e;
  endfunction

  task automatic edge_step();
    @(posedge clk);
    if (n_rst) begin
      q0.push_back(model_step(0, 10, enable, data_ready));
      q1.push_back(model_step(1, 8, enable, data_ready));
    end
  endtask

  task automatic cyc(input logic en, input logic dr);
    @(negedge clk);
    enable = en;
    data_ready = dr;
    edge_step();
  endtask

  // Called just after a negedge: asserts reset mid-cycle, checks outputs clear, then releases.
  task automatic assert_reset(input int hold);
    #2 n_rst = 1'b0;
    #1;
    compare("rst_async_n10", obs0, '0);
    compare("rst_async_n8", obs1, '0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin pos[k] = -1; armed[k] = 1'b0; end
    enable = 1'b1;
    data_ready = 1'b1;
    repeat (hold) begin
      @(negedge clk); #1;
      compare("rst_hold_n10", obs0, '0);
      compare("rst_hold_n8", obs1, '0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    edge_step();
  endtask

  task automatic wait_bc0(input logic [3:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bc0 == target && bsy0) found = 1'b1;
      else edge_step();
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wait_bit_count: bit_count never reached %0d", target);
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin e = q0.pop_front(); compare("seq_n10", obs0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); compare("seq_n8", obs1, e); end
    end
  end

  initial begin : driver
    bit found;
    pos[0] = -1; pos[1] = -1;
    armed[0] = 1'b0; armed[1] = 1'b0;
    @(negedge clk);
    assert_reset(3);
    repeat (40) cyc(1'b1, 1'b1);        // streaming from reset release
    repeat (20) cyc(1'b1, 1'b0);        // underflow at symbol end
    cyc(1'b1, 1'b1);                    // single symbol
    repeat (20) cyc(1'b1, 1'b0);
    repeat (1000) cyc(1'b1, 1'b1);      // 100 symbols of the 10-bit instance
    wait_bc0(4'd3, found);              // graceful stop
    if (found) begin
      enable = 1'b0;
      edge_step();
    end
    repeat (25) cyc(1'b0, 1'b1);
    repeat (15) cyc(1'b1, 1'b1);
    wait_bc0(4'd6, found);              // mid-symbol reset
    if (found) assert_reset(2);
    repeat (30) cyc(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0));
    repeat (20) cyc(1'b0, 1'b0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
